// File: rtl/memory_port_arbiter.sv
// Round-robin sequencer for the 4-port memory controller: grants one client,
// drives port select and access enable, then pulses a one-cycle ack to the winner.
module memory_port_arbiter #(
  parameter int unsigned ACCESS_LATENCY = 1,
  parameter int unsigned HOLD_CYCLES    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [1:0] state,
  output logic       en,
  output logic [3:0] ack,
  output logic       busy,
  output logic [1:0] last_grant
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [1:0] HOLD_INIT = 2'(HOLD_CYCLES - 1);
  localparam logic [3:0] LAT_INIT  = 4'(ACCESS_LATENCY);

  logic [1:0] fsm_r;
  logic [1:0] fsm_s;
  logic [1:0] hold_r;
  logic [1:0] hold_s;
  logic [3:0] lat_r;
  logic [3:0] lat_s;
  logic [1:0] state_s;
  logic       en_s;
  logic [3:0] ack_s;
  logic       busy_s;
  logic [1:0] last_grant_s;
  logic [1:0] winner_s;
  logic       found_s;

  function automatic logic [3:0] port_onehot(input logic [1:0] idx);
    port_onehot = 4'b0001 << idx;
  endfunction

  // Round-robin search starting just after the last acked client; it ends on last_grant itself.
  always_comb begin
    winner_s = 2'd0;
    found_s  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [1:0] cand;
      cand = last_grant + 2'(k);
      if (!found_s && req[cand]) begin
        winner_s = cand;
        found_s  = 1'b1;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next-state and next-output logic; every output is the registered image of these values.
  always_comb begin
    fsm_s        = fsm_r;
    hold_s       = hold_r;
    lat_s        = lat_r;
    state_s      = state;
    en_s         = 1'b0;
    ack_s        = 4'b0000;
    last_grant_s = last_grant;
    case (fsm_r)
      S_IDLE: begin
        if (found_s) begin
          fsm_s   = S_ACCESS;
          state_s = winner_s;
          hold_s  = HOLD_INIT;
          en_s    = 1'b1;
        end else begin
          fsm_s   = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (hold_r == 2'd0) begin
          lat_s = LAT_INIT;
          if (LAT_INIT == 4'd0) begin
            fsm_s        = S_RESP;
            ack_s        = port_onehot(state);
            last_grant_s = state;
          end else begin
            fsm_s        = S_WAIT;
          end
        end else begin
          hold_s = hold_r - 2'd1;
          en_s   = 1'b1;
        end
      end
      S_WAIT: begin
        // The counter reaches zero on this edge, so the ack lands in the next cycle.
        if (lat_r <= 4'd1) begin
          fsm_s        = S_RESP;
          lat_s        = 4'd0;
          ack_s        = port_onehot(state);
          last_grant_s = state;
        end else begin
          lat_s        = lat_r - 4'd1;
        end
      end
      S_RESP: begin
        fsm_s = S_IDLE;
      end
      default: begin
        fsm_s = S_IDLE;
      end
    endcase
    busy_s = (fsm_s != S_IDLE);
  end

  // State and output registers; reset aborts any access in flight without an ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_r      <= S_IDLE;
      hold_r     <= 2'd0;
      lat_r      <= 4'd0;
      state      <= 2'd0;
      en         <= 1'b0;
      ack        <= 4'b0000;
      busy       <= 1'b0;
      last_grant <= 2'd3;
    end else begin
      fsm_r      <= fsm_s;
      hold_r     <= hold_s;
      lat_r      <= lat_s;
      state      <= state_s;
      en         <= en_s;
      ack        <= ack_s;
      busy       <= busy_s;
      last_grant <= last_grant_s;
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Scoreboard bench: two arbiters with different timing parameters, random client
// traffic and resets, checked against a transaction-level round-robin model.
module tb_memory_port_arbiter;

  typedef struct {
    int client;
    int start;
    int ack_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_v   [2];
  logic [3:0] req_v   [2];
  logic [1:0] state_v [2];
  logic       en_v    [2];
  logic [3:0] ack_v   [2];
  logic       busy_v  [2];
  logic [1:0] lg_v    [2];
  logic       rst_q   [2];

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  exp_t       sbq [2][$];
  int         mlg [2];
  int         next_free [2];
  logic [3:0] pend [2];

  memory_port_arbiter #(.ACCESS_LATENCY(1), .HOLD_CYCLES(1)) dut0 (
    .clk(clk), .reset(rst_v[0]), .req(req_v[0]), .state(state_v[0]), .en(en_v[0]),
    .ack(ack_v[0]), .busy(busy_v[0]), .last_grant(lg_v[0]));

  memory_port_arbiter #(.ACCESS_LATENCY(0), .HOLD_CYCLES(2)) dut1 (
    .clk(clk), .reset(rst_v[1]), .req(req_v[1]), .state(state_v[1]), .en(en_v[1]),
    .ack(ack_v[1]), .busy(busy_v[1]), .last_grant(lg_v[1]));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_q[0] <= rst_v[0];
    rst_q[1] <= rst_v[1];
  end

  function automatic int hold_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  // Round-robin rule: search last_grant+1 .. last_grant+4 (mod 4).
  function automatic int pick(input int lg, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(lg + k) % 4]) return (lg + k) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input int i, input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL dut%0d %s at cycle %0d: got %0d, expected %0d", i, name, cyc, act, exp);
    end
  endtask

  task automatic check_inst(input int i);
    exp_t f;
    bit   has;
    bit   e_en;
    bit   e_busy;
    int   e_ack;
    has    = (sbq[i].size() > 0);
    f      = has ? sbq[i][0] : '{client: 0, start: -10, ack_cyc: -10};
    e_en   = has && cyc >= f.start && cyc < f.start + hold_of(i);
    e_busy = has && cyc >= f.start && cyc <= f.ack_cyc;
    e_ack  = (has && cyc == f.ack_cyc) ? (1 << f.client) : 0;
    chk(i, "en", int'(en_v[i]), int'(e_en));
    chk(i, "busy", int'(busy_v[i]), int'(e_busy));
    chk(i, "ack", int'(ack_v[i]), e_ack);
    if (e_busy) chk(i, "state", int'(state_v[i]), f.client);
    if (rst_q[i]) chk(i, "reset_state", int'(state_v[i]), 0);
    if (has && cyc == f.ack_cyc) begin
      mlg[i] = f.client;
      void'(sbq[i].pop_front());
    end
    chk(i, "last_grant", int'(lg_v[i]), mlg[i]);
  endtask

  // Monitor: compares every cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      check_inst(0);
      check_inst(1);
    end
  end

  task automatic step(input int i);
    exp_t e;
    int   w;
    bit   do_rst;
    pend[i] = pend[i] & ~ack_v[i];
    if (cyc >= 1500 && cyc < 2200) begin
      pend[i] = 4'b1111 & ~ack_v[i];
    end else begin
      for (int c = 0; c < 4; c++) begin
        if (!pend[i][c] && $urandom_range(0, 7) == 0) pend[i][c] = 1'b1;
      end
      if ($urandom_range(0, 63) == 0) pend[i][$urandom_range(0, 3)] = 1'b0;
    end
    req_v[i] = pend[i];
    do_rst = (cyc < 2) || ($urandom_range(0, 149) == 0);
    // Aim some resets at the WAIT state of the latency-1 instance.
    if (i == 0 && sbq[0].size() > 0 && cyc == sbq[0][0].start + 1 && ((cyc / 100) % 3) == 0)
      do_rst = 1'b1;
    if (do_rst) begin
      rst_v[i] = 1'b1;
      sbq[i].delete();
      mlg[i] = 3;
      next_free[i] = cyc + 1;
    end else begin
      rst_v[i] = 1'b0;
      if (cyc >= next_free[i] && pend[i] != 4'b0000) begin
        w = pick(mlg[i], pend[i]);
        e.client  = w;
        e.start   = cyc + 1;
        e.ack_cyc = cyc + 1 + hold_of(i) + lat_of(i);
        sbq[i].push_back(e);
        next_free[i] = e.ack_cyc + 1;
      end
    end
  endtask

  // Stimulus and reference model, applied just after the falling edge.
  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_v[i]     = 1'b1;
      req_v[i]     = 4'b0000;
      pend[i]      = 4'b0000;
      mlg[i]       = 3;
      next_free[i] = 0;
    end
    repeat (3000) begin
      @(negedge clk);
      #1;
      step(0);
      step(1);
    end
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
